mem_arbiter: RTL and testbench

- Arbitrates the single-port unified memory of the multicycle CPU between two requesters: the CPU control path (fetch/load/store, selected by iord/memwrite) and a DMA/IO port.
- Grants one access at a time and holds address, data and write enable stable for a fixed number of wait states.
- Returns read data with a one-cycle ack pulse and asserts a stall so the control FSM holds its state until the access completes.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_wait_counter.sv | 29 ++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter and its helpers.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DMA
    } owner_t;

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// Load/increment wait-state counter; terminal flags the last cycle of a LIMIT-cycle window.
module wait_counter
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic inc,
    output logic terminal
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port memory between the CPU control path and a DMA port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t state, state_next;
    owner_t owner, last_grant, grant_owner;
    logic   grant, cnt_load, cnt_inc, cnt_done, access_done;

    wait_counter #(.LIMIT(MEM_LAT)) u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .inc      (cnt_inc),
        .terminal (cnt_done)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        grant_owner = OWN_CPU;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;
        access_done = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    grant      = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = ACCESS;
                    if (cpu_req && dma_req)
                        grant_owner = (last_grant == OWN_CPU) ? OWN_DMA : OWN_CPU;
                    else
                        grant_owner = cpu_req ? OWN_CPU : OWN_DMA;
                end
            end
            ACCESS: begin
                cnt_inc = 1'b1;
                if (cnt_done) begin
                    access_done = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_grant <= OWN_DMA;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            state   <= state_next;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            if (grant) begin
                owner      <= grant_owner;
                last_grant <= grant_owner;
                mem_en     <= 1'b1;
                if (grant_owner == OWN_CPU) begin
                    mem_we    <= cpu_we;
                    mem_addr  <= cpu_addr;
                    mem_wdata <= cpu_wdata;
                end else begin
                    mem_we    <= dma_we;
                    mem_addr  <= dma_addr;
                    mem_wdata <= dma_wdata;
                end
            end
            // Last wait state: read data is valid now, and the ack lands in DONE.
            if (access_done) begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
                if (owner == OWN_CPU) begin
                    cpu_ack <= 1'b1;
                    if (!mem_we) cpu_rdata <= mem_rdata;
                end else begin
                    dma_ack <= 1'b1;
                    if (!mem_we) dma_rdata <= mem_rdata;
                end
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against a transaction-timeline model.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
    logic [AW-1:0] cpu_addr = '0, dma_addr = '0, mem_addr;
    logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0, mem_wdata, mem_rdata;
    logic [DW-1:0] cpu_rdata, dma_rdata;
    logic          cpu_ack, cpu_stall, dma_ack, mem_en, mem_we;

    logic          cpu_req_1 = 0, cpu_we_1 = 0, dma_req_1 = 0, dma_we_1 = 0;
    logic [AW-1:0] cpu_addr_1 = '0, dma_addr_1 = '0, mem_addr_1;
    logic [DW-1:0] cpu_wdata_1 = '0, dma_wdata_1 = '0, mem_wdata_1;
    logic [DW-1:0] mem_rdata_1 = 32'h1357_9BDF;
    logic [DW-1:0] cpu_rdata_1, dma_rdata_1;
    logic          cpu_ack_1, cpu_stall_1, dma_ack_1, mem_en_1, mem_we_1;

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut_lat1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req_1), .cpu_we(cpu_we_1), .cpu_addr(cpu_addr_1), .cpu_wdata(cpu_wdata_1),
        .cpu_rdata(cpu_rdata_1), .cpu_ack(cpu_ack_1), .cpu_stall(cpu_stall_1),
        .dma_req(dma_req_1), .dma_we(dma_we_1), .dma_addr(dma_addr_1), .dma_wdata(dma_wdata_1),
        .dma_rdata(dma_rdata_1), .dma_ack(dma_ack_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_rdata(mem_rdata_1)
    );

    // Environment memory behind the main instance, plus a preset port for loading contents.
    logic [31:0] env_mem [128];
    logic        pre_en = 1'b0;
    logic [6:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;
    assign mem_rdata = mem_en ? env_mem[mem_addr[8:2]] : '0;
    always @(posedge clk) begin
        if (pre_en) env_mem[pre_idx] <= pre_data;
        if (mem_en && mem_we) env_mem[mem_addr[8:2]] <= mem_wdata;
    end

    // Reference model: each grant is a transaction with known grant cycle and ack cycle.
    logic [31:0] ref_mem [128];
    int          cyc = 0, idle_at = 0, g_cyc = 0, a_cyc = 0, win = 0, m_last = 1;
    bit          act = 1'b0, auto_drop = 1'b1;
    logic        e_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, e_rd = '0, x_crd = '0, x_drd = '0;
    int          n_assert = 0, n_fail = 0;
    int          cpu_acks = 0, dma_acks = 0, last_cpu_ack = -1, last_dma_ack = -1;
    int          ack_who [$];
    int          ack_at [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic decide();
        if (reset) begin
            act = 1'b0; m_last = 1; m_addr = '0; m_wdata = '0;
            x_crd = '0; x_drd = '0; idle_at = cyc + 1;
        end else if (!act && cyc >= idle_at && (cpu_req || dma_req)) begin
            if (cpu_req && dma_req) win = (m_last == 1) ? 0 : 1;
            else                    win = cpu_req ? 0 : 1;
            m_last = win; act = 1'b1;
            g_cyc = cyc; a_cyc = cyc + LAT + 1; idle_at = a_cyc + 1;
            if (win == 0) begin e_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata; end
            else          begin e_we = dma_we; m_addr = dma_addr; m_wdata = dma_wdata; end
            if (e_we) ref_mem[m_addr[8:2]] = m_wdata;
            else      e_rd = ref_mem[m_addr[8:2]];
        end
    endtask

    task automatic observe();
        bit xe, xc, xd;
        xe = act && cyc > g_cyc && cyc <= g_cyc + LAT;
        xc = act && win == 0 && cyc == a_cyc;
        xd = act && win == 1 && cyc == a_cyc;
        if (xc && !e_we) x_crd = e_rd;
        if (xd && !e_we) x_drd = e_rd;
        check("mem_en", mem_en, xe);
        check("mem_we", mem_we, xe && e_we);
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
        check("cpu_ack", cpu_ack, xc);
        check("dma_ack", dma_ack, xd);
        check("cpu_rdata", cpu_rdata, x_crd);
        check("dma_rdata", dma_rdata, x_drd);
        check("cpu_stall", cpu_stall, cpu_req & ~xc);
        if (cpu_ack === 1'b1) begin
            cpu_acks++; last_cpu_ack = cyc; ack_who.push_back(0); ack_at.push_back(cyc);
            if (auto_drop) cpu_req = 1'b0;
        end
        if (dma_ack === 1'b1) begin
            dma_acks++; last_dma_ack = cyc; ack_who.push_back(1); ack_at.push_back(cyc);
            if (auto_drop) dma_req = 1'b0;
        end
        if (act && cyc == a_cyc) act = 1'b0;
    endtask

    task automatic tick();
        decide();
        @(negedge clk);
        cyc++;
        observe();
    endtask

    task automatic wait_ack(input int who, input int bound);
        int n0, k;
        n0 = (who == 0) ? cpu_acks : dma_acks;
        k = 0;
        while (((who == 0) ? cpu_acks : dma_acks) == n0 && k < bound) begin
            tick();
            k++;
        end
        check(who == 0 ? "cpu_ack_timeout" : "dma_ack_timeout",
              ((who == 0) ? cpu_acks : dma_acks) > n0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, s, n0;

        // Fill memory while reset is held; outputs must stay at reset values.
        for (int i = 0; i < 128; i++) begin
            pre_en = 1'b1; pre_idx = 7'(i);
            pre_data = (i == 16) ? 32'h8C02_0004 : $urandom;
            ref_mem[i] = pre_data;
            tick();
        end
        pre_en = 1'b0;
        reset = 1'b0;
        tick();

        // MEM_LAT=1 instance: CPU read then DMA write.
        cpu_req_1 = 1'b1; cpu_addr_1 = 32'h80;
        tick();
        check("l1_read_en", mem_en_1, 1'b1);
        check("l1_read_addr", mem_addr_1, 32'h80);
        check("l1_read_noack", cpu_ack_1, 1'b0);
        check("l1_stall", cpu_stall_1, 1'b1);
        tick();
        check("l1_read_en_off", mem_en_1, 1'b0);
        check("l1_read_ack", cpu_ack_1, 1'b1);
        check("l1_read_data", cpu_rdata_1, 32'h1357_9BDF);
        check("l1_stall_off", cpu_stall_1, 1'b0);
        cpu_req_1 = 1'b0;
        dma_req_1 = 1'b1; dma_we_1 = 1'b1; dma_addr_1 = 32'h84; dma_wdata_1 = 32'hCAFE_F00D;
        tick();
        check("l1_ack_pulse", cpu_ack_1, 1'b0);
        check("l1_idle_en", mem_en_1, 1'b0);
        tick();
        check("l1_write_en", mem_en_1, 1'b1);
        check("l1_write_we", mem_we_1, 1'b1);
        check("l1_write_data", mem_wdata_1, 32'hCAFE_F00D);
        tick();
        check("l1_write_ack", dma_ack_1, 1'b1);
        check("l1_write_rdata", dma_rdata_1, 32'h0);
        dma_req_1 = 1'b0;
        tick();

        // CPU read alone at 0x40.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; t0 = cyc;
        wait_ack(0, 10);
        check("cpu_read_latency", last_cpu_ack - t0, 3);
        check("cpu_read_data", cpu_rdata, 32'h8C02_0004);
        tick();

        // DMA write alone at 0x100.
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h100; dma_wdata = 32'hDEAD_BEEF; t0 = cyc;
        wait_ack(1, 10);
        check("dma_write_latency", last_dma_ack - t0, 3);
        check("dma_write_rdata_kept", dma_rdata, 32'h0);
        check("dma_write_mem", env_mem[64], 32'hDEAD_BEEF);
        tick();

        // Both held continuously: strict alternation, CPU first after reset tie-break history.
        reset = 1'b1; tick(); reset = 1'b0;
        auto_drop = 1'b0; s = ack_who.size(); t0 = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h1F0; dma_wdata = 32'h0BAD_F00D;
        for (int k = 0; k < 40 && ack_who.size() < s + 4; k++) tick();
        cpu_req = 1'b0; dma_req = 1'b0; auto_drop = 1'b1;
        check("rr_ack_count", ack_who.size() >= s + 4, 1'b1);
        if (ack_who.size() >= s + 4) begin
            for (int i = 0; i < 4; i++) begin
                check("rr_owner", ack_who[s + i], i % 2);
                check("rr_ack_cycle", ack_at[s + i] - t0, 3 + 4 * i);
            end
        end
        tick();

        // CPU arrives while a DMA access is in progress.
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h44; t0 = cyc;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h48; cpu_wdata = 32'h1234_5678;
        wait_ack(1, 10);
        wait_ack(0, 10);
        check("late_dma_latency", last_dma_ack - t0, 3);
        check("late_cpu_after_dma", last_cpu_ack - last_dma_ack, LAT + 2);
        tick();

        // Reset during the second ACCESS cycle of a CPU read.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        tick();
        tick();
        reset = 1'b1; n0 = cpu_acks;
        tick();
        reset = 1'b0;
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_no_ack", cpu_ack, 1'b0);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h14;
        s = ack_who.size();
        wait_ack(0, 10);
        check("rst_ack_count", cpu_acks, n0 + 1);
        check("rst_cpu_first", ack_who[s], 0);
        wait_ack(1, 10);
        tick();

        // Random traffic, including ignored input changes during an owner's access.
        for (int i = 0; i < 600; i++) begin
            tick();
            if (!cpu_req && last_cpu_ack != cyc && $urandom_range(0, 2) == 0) begin
                cpu_req = 1'b1; cpu_we = 1'($urandom);
                cpu_addr = 32'($urandom_range(0, 127)) << 2; cpu_wdata = $urandom;
            end else if (cpu_req && act && win == 0 && cyc > g_cyc && $urandom_range(0, 3) == 0) begin
                cpu_we = 1'($urandom); cpu_addr = 32'($urandom_range(0, 127)) << 2; cpu_wdata = $urandom;
            end
            if (!dma_req && last_dma_ack != cyc && $urandom_range(0, 2) == 0) begin
                dma_req = 1'b1; dma_we = 1'($urandom);
                dma_addr = 32'($urandom_range(0, 127)) << 2; dma_wdata = $urandom;
            end else if (dma_req && act && win == 1 && cyc > g_cyc && $urandom_range(0, 3) == 0) begin
                dma_we = 1'($urandom); dma_addr = 32'($urandom_range(0, 127)) << 2; dma_wdata = $urandom;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
